// File: rtl/spart_rx_fifo.sv
// Receive-side FIFO for the SPART: captures one byte per rda handshake into an
// 8-deep first-word-fall-through buffer and exposes it to the processor.
module spart_rx_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rda,
    output logic       clr_rda,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic [3:0] count,
    output logic       ovf,
    input  logic       clr_ovf
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACK      = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic [3:0] count_q, count_d;
    logic       clr_rda_q, clr_rda_d;
    logic       ovf_q, ovf_d;
    logic [7:0] mem_q [8];

    logic       capture;
    logic       is_full;
    logic       is_empty;
    logic       push;
    logic       pop;
    logic       drop;

    // Full/empty decisions come from the registered count only.
    always_comb begin
        is_full  = (count_q == 4'd8);
        is_empty = (count_q == 4'd0);
        capture  = (state_q == IDLE) && rda;
        push     = capture && !is_full;
        drop     = capture && is_full;
        pop      = rd_en && !is_empty;
    end

    always_comb begin
        state_d   = state_q;
        clr_rda_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rda) begin
                    state_d   = ACK;
                    clr_rda_d = 1'b1;
                end
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!rda) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 3'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 3'd1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= 3'd0;
            rd_ptr_q  <= 3'd0;
            count_q   <= 4'd0;
            clr_rda_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            clr_rda_q <= clr_rda_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset; only the write is blocked.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= rx_data;
    end

    always_comb begin
        dout    = is_empty ? 8'h00 : mem_q[rd_ptr_q];
        empty   = is_empty;
        full    = is_full;
        count   = count_q;
        clr_rda = clr_rda_q;
        ovf     = ovf_q;
    end

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: directed scenarios plus random traffic checked
// against a queue-based model of the FIFO and its overflow flag.
module tb_spart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rda;
    logic       clr_rda;
    logic       rd_en;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;
    logic       clr_ovf;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;

    spart_rx_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rda     (rda),
        .clr_rda (clr_rda),
        .rd_en   (rd_en),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of the reference: decisions use the occupancy before the edge.
    task automatic model_cycle(input bit push, input logic [7:0] b, input bit pop, input bit clr);
        int pre;
        bit dropped;
        pre = q.size();
        dropped = 1'b0;
        if (pop && pre > 0) void'(q.pop_front());
        if (push) begin
            if (pre < 8) q.push_back(b);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    function automatic logic [7:0] exp_dout();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    // Full receiver handshake: rda high until clr_rda, held one more cycle, then low.
    task automatic drive_byte(input logic [7:0] b, input bit pop, input bit clr,
                              output bit ack1, output bit ack2, output logic [7:0] head_before);
        head_before = dout;
        rda = 1'b1; rx_data = b; rd_en = pop; clr_ovf = clr;
        @(posedge clk); #1;
        model_cycle(1'b1, b, pop, clr);
        rd_en = 1'b0; clr_ovf = 1'b0;
        ack1 = clr_rda;
        @(posedge clk); #1;
        ack2 = clr_rda;
        rda = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive_pop(output logic [7:0] got);
        got = dout;
        rd_en = 1'b1;
        @(posedge clk); #1;
        model_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rda = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete(); m_ovf = 1'b0;
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (clr_rda !== 1'b0) begin miscompares++; $display("FAIL reset_clr_rda: got %b want 0", clr_rda); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", dout); end
    endtask

    task automatic test_single_byte();
        bit a1, a2;
        logic [7:0] h, got;
        drive_byte(8'hA5, 1'b0, 1'b0, a1, a2, h);
        vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL single_ack: got %b want 1", a1); end
        vectors++; if (a2 !== 1'b0) begin miscompares++; $display("FAIL single_ack_once: got %b want 0", a2); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count); end
        vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL single_dout: got %h want a5", dout); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL single_empty: got %b want 0", empty); end
        drive_pop(got);
        vectors++; if (got !== 8'hA5) begin miscompares++; $display("FAIL single_pop: got %h want a5", got); end
    endtask

    task automatic test_fill_overflow();
        bit a1, a2;
        logic [7:0] h;
        for (int i = 1; i <= 9; i++) begin
            drive_byte(8'(i), 1'b0, 1'b0, a1, a2, h);
            if (i == 8) begin
                vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full8: got %b want 1", full); end
                vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL fill_ovf8: got %b want 0", ovf); end
            end
        end
        vectors++; if (a1 !== 1'b1) begin miscompares++; $display("FAIL fill_ack9: got %b want 1", a1); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL fill_ovf: got %b want 1", ovf); end
        vectors++; if (dout !== 8'h01) begin miscompares++; $display("FAIL fill_dout: got %h want 01", dout); end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_count: got %0d want 8", count); end
    endtask

    task automatic test_drain_wrap();
        bit a1, a2;
        logic [7:0] h, got, want;
        for (int i = 1; i <= 8; i++) begin
            want = 8'(i);
            drive_pop(got);
            vectors++; if (got !== want) begin miscompares++; $display("FAIL drain_pop%0d: got %h want %h", i, got, want); end
        end
        for (int i = 0; i < 4; i++) drive_byte(8'h10 + 8'(i), 1'b0, 1'b0, a1, a2, h);
        vectors++; if (count !== 4'd4) begin miscompares++; $display("FAIL wrap_count: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            want = 8'h10 + 8'(i);
            drive_pop(got);
            vectors++; if (got !== want) begin miscompares++; $display("FAIL wrap_pop%0d: got %h want %h", i, got, want); end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_ovf_clear();
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        model_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        clr_ovf = 1'b0;
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_pop_empty();
        bit a1, a2;
        logic [7:0] h, got;
        drive_pop(got);
        vectors++; if (got !== 8'h00) begin miscompares++; $display("FAIL popempty_dout: got %h want 00", got); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL popempty_count: got %0d want 0", count); end
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL popempty_dout_after: got %h want 00", dout); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL popempty_ovf: got %b want 0", ovf); end
        drive_byte(8'h3C, 1'b0, 1'b0, a1, a2, h);
        vectors++; if (dout !== 8'h3C) begin miscompares++; $display("FAIL popempty_ptr: got %h want 3c", dout); end
        drive_pop(got);
    endtask

    task automatic test_simul_count3();
        bit a1, a2;
        logic [7:0] h, got, want;
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 1'b0, 1'b0, a1, a2, h);
        want = exp_dout();
        drive_byte(8'h77, 1'b1, 1'b0, a1, a2, h);
        vectors++; if (h !== want) begin miscompares++; $display("FAIL simul3_head: got %h want %h", h, want); end
        vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL simul3_count: got %0d want 3", count); end
        while (q.size() > 0) begin
            want = q[0];
            drive_pop(got);
            vectors++; if (got !== want) begin miscompares++; $display("FAIL simul3_order: got %h want %h", got, want); end
        end
    endtask

    task automatic test_simul_full();
        bit a1, a2;
        logic [7:0] h;
        for (int i = 0; i < 8; i++) drive_byte(8'hC0 + 8'(i), 1'b0, 1'b0, a1, a2, h);
        drive_byte(8'hEE, 1'b1, 1'b0, a1, a2, h);
        vectors++; if (h !== 8'hC0) begin miscompares++; $display("FAIL simulfull_head: got %h want c0", h); end
        vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL simulfull_count: got %0d want 7", count); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL simulfull_ovf: got %b want 1", ovf); end
        vectors++; if (dout !== 8'hC1) begin miscompares++; $display("FAIL simulfull_dout: got %h want c1", dout); end
        drive_byte(8'hC8, 1'b0, 1'b0, a1, a2, h);
        drive_byte(8'hEF, 1'b0, 1'b1, a1, a2, h);
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_set_wins_count: got %0d want 8", count); end
    endtask

    task automatic test_reset_midhandshake();
        rda = 1'b1; rx_data = 8'h5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); m_ovf = 1'b0;
        vectors++; if (clr_rda !== 1'b0) begin miscompares++; $display("FAIL midrst_clr_rda: got %b want 0", clr_rda); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL midrst_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL midrst_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL midrst_full: got %b want 0", full); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL midrst_dout: got %h want 00", dout); end
        @(posedge clk); #1;
        model_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        vectors++; if (clr_rda !== 1'b1) begin miscompares++; $display("FAIL midrst_recapture_ack: got %b want 1", clr_rda); end
        vectors++; if (dout !== 8'h5A) begin miscompares++; $display("FAIL midrst_recapture_dout: got %h want 5a", dout); end
        @(posedge clk); #1;
        rda = 1'b0;
        @(posedge clk); #1;
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL midrst_recapture_count: got %0d want 1", count); end
    endtask

    task automatic test_random();
        bit a1, a2;
        logic [7:0] h, got, want;
        int op;
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 9));
            want = exp_dout();
            if (op < 5) begin
                drive_byte(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), a1, a2, h);
                vectors++; if ({a1, a2} !== 2'b10) begin miscompares++; $display("FAIL rnd_ack it%0d: got %b%b want 10", it, a1, a2); end
            end else if (op < 8) begin
                drive_pop(got);
                vectors++; if (got !== want) begin miscompares++; $display("FAIL rnd_pop it%0d: got %h want %h", it, got, want); end
            end else begin
                clr_ovf = 1'b1;
                @(posedge clk); #1;
                model_cycle(1'b0, 8'h00, 1'b0, 1'b1);
                clr_ovf = 1'b0;
            end
            vectors++; if (count !== 4'(q.size())) begin miscompares++; $display("FAIL rnd_count it%0d: got %0d want %0d", it, count, q.size()); end
            vectors++; if (dout !== exp_dout()) begin miscompares++; $display("FAIL rnd_dout it%0d: got %h want %h", it, dout, exp_dout()); end
            vectors++; if (ovf !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf it%0d: got %b want %b", it, ovf, m_ovf); end
            vectors++; if ({full, empty} !== {q.size() == 8, q.size() == 0}) begin
                miscompares++; $display("FAIL rnd_flags it%0d: got full=%b empty=%b want size %0d", it, full, empty, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_drain_wrap();
        test_ovf_clear();
        test_pop_empty();
        test_simul_count3();
        test_simul_full();
        test_reset_midhandshake();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
